simple_risc_core: RTL and testbench



---
 rtl/simple_risc_core.sv | 172 +++++++++++++++++
 tb/tb_simple_risc_core.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/simple_risc_core.sv
`default_nettype none
// ============================================================================
// Module      : simple_risc_core
// Description : Multicycle 16-bit RISC execution core (decoder, control FSM,
//               8x16 register file, A/B/C pipeline registers, N/V/Z status).
// Revision    : 1.0 - initial release
// ============================================================================
module simple_risc_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] c_q, c_d;
    logic [2:0]  status_q, status_d;
    logic [15:0] rf_q [8];

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [15:0] sximm8;
    logic        is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp, asel;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign asel       = is_mov_reg || is_mvn;

    logic [15:0] b_sh, a_op, alu_res;
    logic [2:0]  alu_flags;

    always_comb begin
        case (sh)
            2'b01:   b_sh = {b_q[14:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[15:1]};
            2'b11:   b_sh = {b_q[15], b_q[15:1]};
            default: b_sh = b_q;
        endcase
    end

    assign a_op = asel ? 16'h0000 : a_q;

    // MOV-register reuses the adder with a zeroed A operand.
    always_comb begin
        alu_res = a_op + b_sh;
        if (is_alu) begin
            case (op)
                2'b01:   alu_res = a_op - b_sh;
                2'b10:   alu_res = a_op & b_sh;
                2'b11:   alu_res = ~b_sh;
                default: alu_res = a_op + b_sh;
            endcase
        end
    end

    assign alu_flags = {alu_res[15],
                        (a_op[15] != b_sh[15]) && (alu_res[15] != a_op[15]),
                        (alu_res == 16'h0000)};

    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    assign rd_addr  = (state_q == S_GET_A) ? rn : rm;
    assign rd_data  = rf_q[rd_addr];
    // Reset suppresses the write so an interrupted instruction leaves no trace.
    assign rf_we    = !reset && ((state_q == S_WRITE_REG) || (state_q == S_WRITE_IMM));
    assign rf_waddr = (state_q == S_WRITE_IMM) ? rn : rd;
    assign rf_wdata = (state_q == S_WRITE_IMM) ? sximm8 : c_q;

    always_comb begin
        state_d  = state_q;
        ir_d     = load ? in : ir_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;
        case (state_q)
            S_WAIT: begin
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)              state_d = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn) state_d = S_GET_B;
                else if (is_alu)             state_d = S_GET_A;
                else                         state_d = S_WAIT;
            end
            S_GET_A: begin
                a_d     = rd_data;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                b_d     = rd_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_cmp) begin
                    status_d = alu_flags;
                    state_d  = S_WAIT;
                end else begin
                    c_d     = alu_res;
                    state_d = S_WRITE_REG;
                end
            end
            S_WRITE_REG: state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            ir_q     <= 16'h0000;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            c_q      <= 16'h0000;
            status_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end

    assign out       = c_q;
    assign {N, V, Z} = status_q;
    assign w         = (state_q == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_simple_risc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_risc_core
// Description : Scoreboard bench for simple_risc_core using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_risc_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] ins_in;
    logic [15:0] out;
    logic        N, V, Z, w;

    simple_risc_core dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .load  (load),
        .in    (ins_in),
        .out   (out),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .w     (w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic [2:0]  nvz;
        int          s_edge;
        int          lat;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];
    bit   done = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic wait_w();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (w) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            $display("FAIL wait_w: w stayed %b, want 1 within 20 cycles", w);
            $fatal(1, "timeout");
        end
    endtask

    task automatic run(input string name, input logic [15:0] ins,
                       input logic [15:0] eout, input logic [2:0] envz,
                       input int lat);
        exp_t e;
        @(negedge clk);
        load = 1'b1; ins_in = ins;
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        e.name = name; e.out = eout; e.nvz = envz;
        e.s_edge = cyc + 1; e.lat = lat; e.chk_lat = 1'b1;
        q.push_back(e);
        @(negedge clk);
        s = 1'b0;
        wait_w();
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; s = 1'b0; load = 1'b0; ins_in = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run("mov_r0_imm7",   16'hD007, 16'h0000, 3'b000, 3);
        run("mov_r1_lsl",    16'hC028, 16'h000E, 3'b000, 5);
        run("mov_r2_imm_m1", 16'hD2FF, 16'h000E, 3'b000, 3);
        run("add_r3",        16'hA062, 16'h0006, 3'b000, 6);
        run("cmp_r0_r0",     16'hA800, 16'h0006, 3'b001, 5);
        run("cmp_r2_r0",     16'hAA00, 16'h0006, 3'b100, 5);
        run("mvn_r6",        16'hB8C0, 16'hFFF8, 3'b100, 5);
        run("and_r7_asr",    16'hB2F8, 16'h0003, 3'b100, 6);
        run("mov_r4_lsr",    16'hC092, 16'h7FFF, 3'b100, 5);
        run("cmp_overflow",  16'hAC02, 16'h7FFF, 3'b110, 5);
        run("undefined_nop", 16'h0000, 16'h7FFF, 3'b110, 2);

        // ADD R3,R0,R1 interrupted by reset while in GET_B
        @(negedge clk);
        load = 1'b1; ins_in = 16'hA061;
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        e.name = "reset_abort"; e.out = 16'h0000; e.nvz = 3'b000;
        e.s_edge = cyc + 1; e.lat = 0; e.chk_lat = 1'b0;
        q.push_back(e);
        @(negedge clk);
        s = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        run("mov_r1_r3",     16'hC023, 16'h0006, 3'b000, 5);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

    initial begin
        exp_t e;
        bit   w_prev;
        int   lat;
        repeat (2) @(negedge clk);
        total++; if (w !== 1'b1) begin bad++; $display("FAIL reset_w: got %b want 1", w); end
        total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", out); end
        total++; if ({N, V, Z} !== 3'b000) begin bad++; $display("FAIL reset_nvz: got %b want 000", {N, V, Z}); end
        w_prev = w;
        forever begin
            @(negedge clk);
            if (done) begin
                total++;
                if (q.size() != 0) begin
                    bad++;
                    $display("FAIL pending: got %0d outstanding want 0", q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (!w_prev && w) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got completion at cycle %0d want none", cyc);
                end else begin
                    e = q.pop_front();
                    if (out !== e.out) begin
                        bad++;
                        $display("FAIL %s out: got %h want %h", e.name, out, e.out);
                    end
                    total++;
                    if ({N, V, Z} !== e.nvz) begin
                        bad++;
                        $display("FAIL %s nvz: got %b want %b", e.name, {N, V, Z}, e.nvz);
                    end
                    if (e.chk_lat) begin
                        lat = cyc - e.s_edge + 1;
                        total++;
                        if (lat != e.lat) begin
                            bad++;
                            $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat);
                        end
                    end
                end
            end
            w_prev = w;
        end
    end

endmodule
`default_nettype wire
